// File: rtl/io_bus_arbiter_if.sv
// Master-side request/completion signals and shared device bus for io_bus_arbiter.
// The tri-state data bus stays a plain inout port on the arbiter so it can resolve with device drivers.
interface io_bus_arbiter_if #(
  parameter int BITS = 32
);
  logic            flush;
  logic            m0_req;
  logic            m0_we;
  logic [BITS-1:0] m0_addr;
  logic [BITS-1:0] m0_wdata;
  logic            m0_done;
  logic            m1_req;
  logic            m1_we;
  logic [BITS-1:0] m1_addr;
  logic [BITS-1:0] m1_wdata;
  logic            m1_done;
  logic [BITS-1:0] rdata;
  logic [BITS-1:0] abus;
  logic            we;

  modport master (
    output flush, m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_done, m1_done, rdata, abus, we
  );

  modport slave (
    input  flush, m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_done, m1_done, rdata, abus, we
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for a shared IO device bus: IDLE -> ACCESS -> DONE, one transaction per 3 cycles.
// Define IO_ARB_ROUND_ROBIN_EN for round-robin between masters; default is fixed priority with M0 first.
module io_bus_arbiter #(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] IDLE_ADDR = '0
) (
  input  logic            clk,
  input  logic            lock,
  io_bus_arbiter_if.slave bus,
  inout  wire [BITS-1:0]  dbus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            load;
  logic            m0_ok;
  logic            m1_ok;
  logic            pick_m1;
  logic [BITS-1:0] addr_q;
  logic [BITS-1:0] wdata_q;
  logic            we_q;
  logic            gid_q;
  logic [BITS-1:0] rdata_q;
  logic            m0_done_q;
  logic            m1_done_q;

  // FLUSH only holds back new CPU grants; the DMA/debug master is never gated.
  assign m0_ok = bus.m0_req && !bus.flush;
  assign m1_ok = bus.m1_req;

`ifdef IO_ARB_ROUND_ROBIN_EN
  logic last_m1;

  assign pick_m1 = m1_ok && (!m0_ok || !last_m1);

  always_ff @(posedge clk or negedge lock) begin
    if (!lock) begin
      last_m1 <= 1'b1;
    end else if (load) begin
      last_m1 <= pick_m1;
    end
  end
`else
  assign pick_m1 = m1_ok && !m0_ok;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (m0_ok || m1_ok) begin
          load       = 1'b1;
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge lock) begin
    if (!lock) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      gid_q     <= 1'b0;
      rdata_q   <= '0;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
    end else begin
      state     <= state_next;
      m0_done_q <= (state == S_ACCESS) && !gid_q;
      m1_done_q <= (state == S_ACCESS) && gid_q;
      if (load) begin
        addr_q  <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
        wdata_q <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
        we_q    <= pick_m1 ? bus.m1_we    : bus.m0_we;
        gid_q   <= pick_m1;
      end
      if ((state == S_ACCESS) && !we_q) begin
        rdata_q <= dbus;
      end
    end
  end

  // The device bus carries latched request data only during ACCESS; reset drops it immediately.
  assign bus.abus    = (state == S_ACCESS) ? addr_q : IDLE_ADDR;
  assign bus.we      = (state == S_ACCESS) && we_q;
  assign dbus        = ((state == S_ACCESS) && we_q) ? wdata_q : {BITS{1'bz}};
  assign bus.rdata   = rdata_q;
  assign bus.m0_done = m0_done_q;
  assign bus.m1_done = m1_done_q;

endmodule
